mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequential scan controller that drives the 2-bit select pair of the 4:1 mux stage and collects the mux output Z.
- Steps through enabled channels 0..3 and holds each select for DWELL cycles so the mux output settles.
- Samples Z on the last dwell cycle of each channel and assembles a 4-bit frame.
- Publishes the frame with a one-cycle valid pulse. Single-shot or continuous operation.

Parameters:
- DWELL, 4, cycles each select value is held; legal range 1..255.
- DWELL_W, 8, width of the dwell counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a scan; accepted only in IDLE.
- cont  input  1  continuous mode; while high, a new frame starts immediately after DONE.
- chan_en  input  4  per-channel enable; latched when start is accepted.
- z_in  input  1  mux output Z.
- sel_a  output  1  select LSB, drives mux input a.
- sel_b  output  1  select MSB, drives mux input b.
- frame  output  4  last completed frame; bit i = Z sampled on channel i.
- frame_valid  output  1  one-cycle pulse when frame updates.
- busy  output  1  high in SCAN and DONE.

Behaviour:
- Reset: one clock with rst=1 gives state IDLE, sel_a=sel_b=0, frame=0, frame_valid=0, busy=0, counter=0, latched enables=0.
- rst is honoured in any state; a scan in progress is aborted and its partial frame is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Select outputs are held at 00.
  - On start=1: latch chan_en, set chan = lowest enabled index, cnt=0, go to SCAN.
  - If the latched enable is 0000, go directly to DONE.
- SCAN:
  - {sel_b,sel_a} = chan, registered.
  - cnt increments every cycle.
  - When cnt==DWELL-1: shadow[chan] <= z_in, cnt <= 0, chan <= next higher enabled index.
  - If no higher enabled index exists, go to DONE.
- DONE (one cycle):
  - frame <= shadow with disabled bits forced to 0; frame_valid=1.
  - If cont=1, re-latch chan_en and re-enter SCAN, as on start.
  - Otherwise go to IDLE.
- Shadow register is cleared when a scan begins.
- Latency: frame_valid rises N_en*DWELL+1 cycles after the start edge, where N_en is the number of enabled channels. All enabled with DWELL=4 gives 17 cycles.
- start while busy is ignored, with no queuing.
- chan_en changes during a scan are ignored.
- cont deasserted mid-frame: the current frame completes, then IDLE.
- start and cont both high in IDLE: behaves as start.
- frame holds its value between pulses.
- DWELL=1: one cycle per channel. The select becomes valid in the same cycle z_in is sampled, so the mux path must be combinational.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined: adds output frame_par (1 bit) = XOR of the frame bits. It is registered with frame, updates on the frame_valid cycle, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - CH_NUM=4, SEL_W=2.
  - Function first_en(en, from) returning the next enabled index plus a found flag.
- Sub-module mux_scan_next_ch: combinational priority finder. Inputs: 4-bit enable, 2-bit current index, a "from start" flag. Outputs: next index, found. Used for both the initial channel pick and channel advance.

Test Plan:
- Reset: hold rst=1 for 2 cycles during an active scan -> next cycle frame=0, frame_valid=0, busy=0, sel=00.
- Full scan: bench mux model with A..D=1,0,1,0, DWELL=4, chan_en=1111, start pulse -> sel sequence 00,01,10,11 for 4 cycles each; frame_valid at cycle 17; frame=4'b0101 (bit0=A).
- Sparse enables: chan_en=1010, same data -> only sel 01 and 11 appear; frame_valid at cycle 9; frame=4'b0000 (B=0, D=0). Then A..D=0,1,0,1 -> frame=4'b1010.
- Empty enables: chan_en=0000, start -> frame_valid at cycle 1, frame=0, no select change.
- Continuous mode and ignored start: cont=1 for 3 frames with start pulsed mid-scan -> frame_valid every 17 cycles; the extra start has no effect; drop cont -> IDLE after the current frame.
- Parity (macro on): frame=4'b0111 -> frame_par=1; frame=4'b0101 -> frame_par=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and the enabled-channel search used by the mux scan controller.
package mux_scan_pkg;
   localparam int CH_NUM = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Lowest enabled channel whose index is >= from; from may be CH_NUM (nothing left).
   function automatic pick_t first_en(input logic [CH_NUM-1:0] en, input logic [SEL_W:0] from);
      pick_t r;
      r = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (en[i] && (i >= int'(from))) begin
            r.found = 1'b1;
            r.idx   = SEL_W'(i);
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational priority finder: first enabled channel from 0, or the next one above cur.
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [CH_NUM-1:0] en,
   input  logic [SEL_W-1:0]  cur,
   input  logic              from_start,
   output logic [SEL_W-1:0]  next_idx,
   output logic              found
);
   logic [SEL_W:0] from;
   pick_t          pick;

   assign from     = from_start ? '0 : ({1'b0, cur} + 1'b1);
   assign pick     = first_en(en, from);
   assign next_idx = pick.idx;
   assign found    = pick.found;
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 4:1 mux stage: dwells on each enabled select, samples Z, publishes a frame.
// Optional MUX_SCAN_PARITY_EN adds frame_par, the XOR of the published frame.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL   = 4,
   parameter int DWELL_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic [CH_NUM-1:0] chan_en,
   input  logic              z_in,
   output logic              sel_a,
   output logic              sel_b,
   output logic [CH_NUM-1:0] frame,
   output logic              frame_valid,
`ifdef MUX_SCAN_PARITY_EN
   output logic              frame_par,
`endif
   output logic              busy
);
   // state | meaning
   // IDLE  | select parked at 00, waiting for start
   // SCAN  | holding select on chan for DWELL cycles, sampling Z on the last one
   // DONE  | one cycle: publish frame, relaunch if cont else return to IDLE

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    chan_q, chan_d, sel_q, sel_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic [CH_NUM-1:0]   en_q, en_d, shadow_q, shadow_d, frame_q, frame_d;
   logic                valid_q, valid_d;

   logic [CH_NUM-1:0]   pk_en;
   logic                pk_start, pk_found;
   logic [SEL_W-1:0]    pk_idx;

   mux_scan_next_ch u_next_ch (
      .en         (pk_en),
      .cur        (chan_q),
      .from_start (pk_start),
      .next_idx   (pk_idx),
      .found      (pk_found)
   );

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      valid_d  = 1'b0;
      pk_en    = en_q;
      pk_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               pk_en    = chan_en;
               pk_start = 1'b1;
               en_d     = chan_en;
               shadow_d = '0;
               cnt_d    = '0;
               chan_d   = pk_idx;
               state_d  = pk_found ? SCAN : DONE;
            end
         end
         SCAN: begin
            cnt_d = cnt_q + DWELL_W'(1);
            if (cnt_q == DWELL_W'(DWELL - 1)) begin
               shadow_d[chan_q] = z_in;
               cnt_d            = '0;
               if (pk_found) chan_d = pk_idx;
               else          state_d = DONE;
            end
         end
         DONE: begin
            frame_d = shadow_q & en_q;
            valid_d = 1'b1;
            if (cont) begin
               pk_en    = chan_en;
               pk_start = 1'b1;
               en_d     = chan_en;
               shadow_d = '0;
               cnt_d    = '0;
               chan_d   = pk_idx;
               state_d  = pk_found ? SCAN : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Select is registered alongside chan so it is valid in the cycle Z is sampled.
      sel_d = (state_d == SCAN) ? chan_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         chan_q   <= '0;
         sel_q    <= '0;
         cnt_q    <= '0;
         en_q     <= '0;
         shadow_q <= '0;
         frame_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         valid_q  <= valid_d;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic par_q;
   always_ff @(posedge clk) begin
      if (rst)          par_q <= 1'b0;
      else if (valid_d) par_q <= ^frame_d;
   end
   assign frame_par = par_q;
`endif

   assign sel_a       = sel_q[0];
   assign sel_b       = sel_q[1];
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: vector table of single scans plus reset and continuous sequences.
module tb_mux_scan_ctrl;
   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst, start, cont, z_in;
   logic [3:0] chan_en, frame, mux_data;
   logic       sel_a, sel_b, frame_valid, busy;
`ifdef MUX_SCAN_PARITY_EN
   logic       frame_par;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Bench model of the 4:1 mux: bit i of mux_data is input i (A = bit 0).
   assign z_in = mux_data[{sel_b, sel_a}];

   mux_scan_ctrl #(.DWELL(DW), .DWELL_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cont        (cont),
      .chan_en     (chan_en),
      .z_in        (z_in),
      .sel_a       (sel_a),
      .sel_b       (sel_b),
      .frame       (frame),
      .frame_valid (frame_valid),
`ifdef MUX_SCAN_PARITY_EN
      .frame_par   (frame_par),
`endif
      .busy        (busy)
   );

   typedef struct {
      logic [3:0] en;
      logic [3:0] data;
      logic [3:0] exp_frame;
      int         exp_lat;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_scan(input logic [3:0] en, input logic [3:0] data,
                          input logic [3:0] exp_frame, input int exp_lat);
      int list[4];
      int n;
      int lat;
      bit sel_bad;
      n = 0;
      for (int i = 0; i < 4; i++) if (en[i]) begin list[n] = i; n++; end
      @(negedge clk);
      mux_data = data;
      chan_en  = en;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      chan_en = ~en;
      check("busy_after_start", busy, 1);
      lat     = -1;
      sel_bad = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (k < n * DW) begin
            if (int'({sel_b, sel_a}) != list[k / DW]) sel_bad = 1'b1;
         end else if ({sel_b, sel_a} != 2'b00) begin
            sel_bad = 1'b1;
         end
         if (frame_valid) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      check("latency", lat, exp_lat);
      check("frame", frame, exp_frame);
      check("sel_sequence_ok", sel_bad, 0);
`ifdef MUX_SCAN_PARITY_EN
      check("frame_par", frame_par, ^exp_frame);
`endif
      @(negedge clk);
      check("valid_one_cycle", frame_valid, 0);
      check("idle_after_done", busy, 0);
      check("frame_holds", frame, exp_frame);
   endtask

   initial begin
      vecs[0] = '{4'b1111, 4'b0101, 4'b0101, 17};
      vecs[1] = '{4'b1010, 4'b0101, 4'b0000, 9};
      vecs[2] = '{4'b1010, 4'b1010, 4'b1010, 9};
      vecs[3] = '{4'b0000, 4'b1111, 4'b0000, 1};
      vecs[4] = '{4'b0001, 4'b1111, 4'b0001, 5};
      vecs[5] = '{4'b0110, 4'b1111, 4'b0110, 9};
      vecs[6] = '{4'b0111, 4'b0111, 4'b0111, 13};

      rst = 1'b1; start = 1'b0; cont = 1'b0; chan_en = 4'h0; mux_data = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_frame", frame, 0);
      check("rst_valid", frame_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sel", {sel_b, sel_a}, 0);
`ifdef MUX_SCAN_PARITY_EN
      check("rst_par", frame_par, 0);
`endif

      for (int v = 0; v < 7; v++)
         do_scan(vecs[v].en, vecs[v].data, vecs[v].exp_frame, vecs[v].exp_lat);

      // Reset mid-scan: partial frame dropped, previous frame cleared.
      begin
         int nv;
         @(negedge clk);
         mux_data = 4'b1111; chan_en = 4'b1111; start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         repeat (6) @(negedge clk);
         rst = 1'b1;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         check("midrst_frame", frame, 0);
         check("midrst_valid", frame_valid, 0);
         check("midrst_busy", busy, 0);
         check("midrst_sel", {sel_b, sel_a}, 0);
         nv = 0;
         for (int k = 0; k < 30; k++) begin
            if (frame_valid) nv++;
            @(negedge clk);
         end
         check("midrst_no_frame", nv, 0);
      end

      // Continuous mode with an ignored start pulse mid-scan, cont dropped during frame 3.
      begin
         int  nv;
         @(negedge clk);
         mux_data = 4'b0101; chan_en = 4'b1111; start = 1'b1; cont = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         nv = 0;
         for (int k = 0; k < 80; k++) begin
            if (k == 8)  start = 1'b1;
            if (k == 9)  start = 1'b0;
            if (k == 40) cont  = 1'b0;
            if (frame_valid) begin
               check("cont_valid_cycle", k, 17 * (nv + 1));
               check("cont_frame", frame, 4'b0101);
               nv++;
            end
            if (k == 52) check("cont_idle_after", busy, 0);
            @(negedge clk);
         end
         check("cont_frame_count", nv, 3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
